// File: rtl/ex_mul_ctrl.sv
// EX-stage sequencer for the multi-cycle multiplier: start/annul handshake, HI/LO/GPR update.
// Latency: write-back one cycle after mul_ready_i (two for accumulate ops).
// Backpressure: stallreq_o holds IF/ID/EX from accept until DONE; flush_i aborts in flight.
module ex_mul_ctrl #(
   parameter bit ACC_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic        flush_i,
   output logic        mul_start_o,
   output logic        mul_annul_o,
   output logic        mul_signed_o,
   output logic [31:0] mul_op1_o,
   output logic [31:0] mul_op2_o,
   input  logic [63:0] mul_result_i,
   input  logic        mul_ready_i,
   output logic        stallreq_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o
);

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MUL   = 3'd3;
   localparam logic [2:0] OP_MADD  = 3'd4;
   localparam logic [2:0] OP_MSUB  = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACC  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] op1_q, op1_d;
   logic [31:0] op2_q, op2_d;
   logic        signed_q, signed_d;
   logic        start_q, start_d;
   logic        annul_q, annul_d;
   logic [63:0] prod_q, prod_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] wdata_q, wdata_d;

   logic        accept;
   logic        op_is_acc;
   logic        op_is_sub;
   logic        op_is_mul;
   logic [63:0] acc_sum;

   // Accept a valid op in IDLE; accumulate ops only exist when ACC_EN is set
   always_comb begin
      accept = 1'b0;
      if (state_q == ST_IDLE && !flush_i && op_i != OP_NOP) begin
         accept = ACC_EN ? 1'b1 : (op_i < OP_MADD);
      end
   end

   // Decode of the latched op and the 64-bit accumulate (wraps modulo 2^64)
   always_comb begin
      op_is_acc = (op_q >= OP_MADD);
      op_is_sub = (op_q >= OP_MSUB);
      op_is_mul = (op_q == OP_MUL);
      acc_sum   = op_is_sub ? ({hi_i, lo_i} - prod_q) : ({hi_i, lo_i} + prod_q);
   end

   // State register and all datapath flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= 3'd0;
         op1_q    <= 32'd0;
         op2_q    <= 32'd0;
         signed_q <= 1'b0;
         start_q  <= 1'b0;
         annul_q  <= 1'b0;
         prod_q   <= 64'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         wdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         signed_q <= signed_d;
         start_q  <= start_d;
         annul_q  <= annul_d;
         prod_q   <= prod_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         wdata_q  <= wdata_d;
      end
   end

   // Next-state and next-datapath logic; operands/sign only load on accept so they stay frozen while start is high
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      signed_d = signed_q;
      start_d  = start_q;
      annul_d  = 1'b0;
      prod_d   = prod_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      wdata_d  = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d     = op_i;
               op1_d    = rs_i;
               op2_d    = rt_i;
               signed_d = (op_i == OP_MULT) || (op_i == OP_MUL) ||
                          (op_i == OP_MADD) || (op_i == OP_MSUB);
               start_d  = 1'b1;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (flush_i) begin
               start_d = 1'b0;
               annul_d = 1'b1;
               state_d = ST_IDLE;
            end else if (mul_ready_i) begin
               prod_d = mul_result_i;
               if (op_is_acc) begin
                  state_d = ST_ACC;
               end else begin
                  if (op_is_mul) begin
                     wdata_d = mul_result_i[31:0];
                  end else begin
                     hi_d = mul_result_i[63:32];
                     lo_d = mul_result_i[31:0];
                  end
                  state_d = ST_DONE;
               end
            end
         end
         ST_ACC: begin
            if (flush_i) begin
               start_d = 1'b0;
               state_d = ST_IDLE;
            end else begin
               hi_d    = acc_sum[63:32];
               lo_d    = acc_sum[31:0];
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // Multiplier is released on this edge; the next op can start after one idle cycle
            start_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            start_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode: write enables only in DONE and suppressed by a same-cycle flush
   always_comb begin
      mul_start_o  = start_q;
      mul_annul_o  = annul_q;
      mul_signed_o = signed_q;
      mul_op1_o    = op1_q;
      mul_op2_o    = op2_q;
      hi_o         = hi_q;
      lo_o         = lo_q;
      wdata_o      = wdata_q;
      stallreq_o   = accept || (state_q == ST_WAIT) || (state_q == ST_ACC);
      whilo_o      = (state_q == ST_DONE) && !flush_i && !op_is_mul;
      wreg_o       = (state_q == ST_DONE) && !flush_i && op_is_mul;
   end

endmodule
